// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read/write/reserve bus of the scoreboarded register file
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_conflict;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_conflict, busy_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_conflict, busy_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R1W register file with per-register busy scoreboard
// Optional REG_FILE_SB_BYPASS_EN: forward same-cycle writes to the read ports.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ok, rsv_ok, same_addr, set_new, clr_new;
  logic [DATA_W:0]   port1, port2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Hardwired-zero accesses are filtered here so nothing downstream sees them.
  assign wr_ok     = bus.wr_en  && !is_zero(bus.wr_addr);
  assign rsv_ok    = bus.rsv_en && !is_zero(bus.rsv_addr);
  assign same_addr = (bus.wr_addr == bus.rsv_addr);

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
  end

  // Incremental count; a same-address write+reserve leaves the bit set, so no clear.
  assign set_new = rsv_ok && !busy_q[bus.rsv_addr];
  assign clr_new = wr_ok && busy_q[bus.wr_addr] && !(rsv_ok && same_addr);
  assign count_d = count_q + CNT_W'(set_new) - CNT_W'(clr_new);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {busy_q[a], regs_q[a]};
    if (is_zero(a)) r = '0;
`ifdef REG_FILE_SB_BYPASS_EN
    else if (wr_ok && (a == bus.wr_addr)) r = {rsv_ok && same_addr, bus.wr_data};
`endif
    return r;
  endfunction

  always_comb begin
    port1 = read_port(bus.rd_addr1);
    port2 = read_port(bus.rd_addr2);
  end

  assign bus.rd_data1     = port1[DATA_W-1:0];
  assign bus.rd_busy1     = port1[DATA_W];
  assign bus.rd_data2     = port2[DATA_W-1:0];
  assign bus.rd_busy2     = port2[DATA_W];
  assign bus.rsv_conflict = rsv_ok && busy_q[bus.rsv_addr];
  assign bus.busy_count   = count_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (ZERO_REG=1 and ZERO_REG=0)
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;

  logic        cur_we, cur_re;
  logic [4:0]  cur_wa, cur_ra, cur_a1, cur_a2;
  logic [31:0] cur_wd;

  // Reference: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0
  logic [31:0] mreg [2][32];
  logic [31:0] mbusy [2];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_conf;
    logic [5:0]  e_cnt;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a1, input logic [4:0] a2);
    cur_we = we; cur_wa = wa; cur_wd = wd; cur_re = re; cur_ra = ra; cur_a1 = a1; cur_a2 = a2;
    ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd; ifa.rsv_en = re; ifa.rsv_addr = ra;
    ifa.rd_addr1 = a1; ifa.rd_addr2 = a2;
    ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.rsv_en = re; ifb.rsv_addr = ra;
    ifb.rd_addr1 = a1; ifb.rd_addr2 = a2;
  endtask

  function automatic logic m_zero(input int m, input logic [4:0] a);
    return (m == 0) && (a == 5'd0);
  endfunction

  function automatic logic [32:0] m_read(input int m, input logic [4:0] a);
    logic [32:0] r;
    r = {mbusy[m][a], mreg[m][a]};
    if (m_zero(m, a)) r = '0;
`ifdef REG_FILE_SB_BYPASS_EN
    else if (cur_we && a == cur_wa) r = {cur_re && (cur_ra == cur_wa), cur_wd};
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = '0;
      for (int i = 0; i < 32; i++) mreg[m][i] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (cur_we && !m_zero(m, cur_wa)) begin
        mreg[m][cur_wa]  = cur_wd;
        mbusy[m][cur_wa] = 1'b0;
      end
      if (cur_re && !m_zero(m, cur_ra)) mbusy[m][cur_ra] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic check_all();
    chk("a_rd1", 64'({ifa.rd_busy1, ifa.rd_data1}), 64'(m_read(0, cur_a1)));
    chk("a_rd2", 64'({ifa.rd_busy2, ifa.rd_data2}), 64'(m_read(0, cur_a2)));
    chk("b_rd1", 64'({ifb.rd_busy1, ifb.rd_data1}), 64'(m_read(1, cur_a1)));
    chk("b_rd2", 64'({ifb.rd_busy2, ifb.rd_data2}), 64'(m_read(1, cur_a2)));
    chk("a_conf", 64'(ifa.rsv_conflict), 64'(cur_re && !m_zero(0, cur_ra) && mbusy[0][cur_ra]));
    chk("b_conf", 64'(ifb.rsv_conflict), 64'(cur_re && mbusy[1][cur_ra]));
    chk("a_cnt", 64'(ifa.busy_count), 64'($countones(mbusy[0])));
    chk("b_cnt", 64'(ifb.busy_count), 64'($countones(mbusy[1])));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Async reset between edges, with a reservation still asserted
    drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5); tick();
    drive(0, 0, 0, 1, 5, 5, 5); tick();
    chk("pre_rst_data", 64'(ifa.rd_data1), 64'h0000_0000_DEAD_BEEF);
    chk("pre_rst_conf", 64'(ifa.rsv_conflict), 64'd1);
    chk("pre_rst_cnt", 64'(ifa.busy_count), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_data", 64'(ifa.rd_data1), 64'd0);
    chk("rst_busy", 64'(ifa.rd_busy1), 64'd0);
    chk("rst_cnt", 64'(ifa.busy_count), 64'd0);
    chk("rst_conf", 64'(ifa.rsv_conflict), 64'd0);
    chk("rst_b_data", 64'(ifb.rd_data2), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        1'b1, 1'b1, 6'd1};
    tbl[2]  = '{1'b1, 5'd7, 32'hA5,       1'b0, 5'd0, 5'd3, 32'h0,        1'b0, 1'b0, 6'd1};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'hA5,       1'b0, 1'b0, 6'd0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[5]  = '{1'b1, 5'd9, 32'h55,       1'b1, 5'd9, 5'd3, 32'h0,        1'b0, 1'b1, 6'd1};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd9, 32'h55,       1'b1, 1'b0, 6'd1};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 6'd1};
    tbl[8]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd9, 32'h55,       1'b1, 1'b0, 6'd1};
    tbl[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd3, 32'h12345678, 1'b0, 1'b0, 6'd1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 6'd1};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].a, tbl[i].a);
      #1;
      chk($sformatf("tbl%0d_data1", i), 64'(ifa.rd_data1), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_data2", i), 64'(ifa.rd_data2), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_busy", i), 64'(ifa.rd_busy1), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_conf", i), 64'(ifa.rsv_conflict), 64'(tbl[i].e_conf));
      chk($sformatf("tbl%0d_cnt", i), 64'(ifa.busy_count), 64'(tbl[i].e_cnt));
      tick();
    end
    chk("b_r0_ordinary", 64'(ifb.rd_data1), 64'hFFFF_FFFF);

    // Same-cycle write visibility with and without forwarding
    drive(1, 4, 32'h1111, 0, 0, 4, 4); tick();
    drive(1, 4, 32'hCAFE, 0, 0, 4, 4); #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("byp_data", 64'(ifa.rd_data1), 64'hCAFE);
    chk("byp_busy", 64'(ifa.rd_busy1), 64'd0);
`else
    chk("nobyp_data", 64'(ifa.rd_data1), 64'h1111);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 4, 4); #1;
    chk("post_wr_data", 64'(ifa.rd_data1), 64'hCAFE);
    drive(1, 4, 32'hBEEF, 1, 4, 4, 4); #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("byp_rsv_data", 64'(ifa.rd_data2), 64'hBEEF);
    chk("byp_rsv_busy", 64'(ifa.rd_busy2), 64'd1);
`else
    chk("nobyp_rsv_busy", 64'(ifa.rd_busy2), 64'd0);
`endif
    tick();

    // Saturation and drain
    do_reset();
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 1, 5'(i), 5'(i), 5'(i));
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 31); #1;
    chk("sat_a_cnt", 64'(ifa.busy_count), 64'd31);
    chk("sat_b_cnt", 64'(ifb.busy_count), 64'd31);
    chk("sat_r0_conf", 64'(ifa.rsv_conflict), 64'd0);
    chk("sat_busy31", 64'(ifa.rd_busy2), 64'd1);
    tick();
    #1;
    chk("sat_a_r0", 64'(ifa.busy_count), 64'd31);
    chk("sat_b_full", 64'(ifb.busy_count), 64'd32);
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'(i), 32'(i * 3), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 30, 31); #1;
    chk("drain_a_cnt", 64'(ifa.busy_count), 64'd0);
    chk("drain_b_cnt", 64'(ifb.busy_count), 64'd0);
    chk("drain_data", 64'(ifa.rd_data2), 64'd93);

    // Random write/reserve mix against the reference model
    do_reset();
    #1;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) begin
        cur_a1 = cur_wa;
        ifa.rd_addr1 = cur_wa;
        ifb.rd_addr1 = cur_wa;
      end
      #1;
      check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
